// File: rtl/rv_decode_stage.sv
// RV32I instruction-decode stage: ID/EX pipeline register, raw immediate extraction and a 32x32 register file.
// Optional macro RV_DECODE_WB_BYPASS_EN forwards a same-edge MEM/WB write into the rs1/rs2 read.
module rv_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_ir,
    input  logic [31:0] if_id_pc,
    input  logic [31:0] mem_wb_ir,
    input  logic [31:0] mem_wb_out,
    output logic [31:0] id_ex_ir,
    output logic [31:0] id_ex_pc,
    output logic [31:0] id_ex_rs1,
    output logic [31:0] id_ex_rs2,
    output logic [19:0] id_ex_imm
);
    // No stalls or handshakes: every input is captured on every rising edge.

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0] regs_q [0:31];
    logic [31:0] ir_q;
    logic [31:0] pc_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [19:0] imm_q;

    logic [31:0] rs1_d;
    logic [31:0] rs2_d;
    logic [19:0] imm_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [6:0]  wb_opcode;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic        unused_wb_bits;

    assign opcode    = if_id_ir[6:0];
    assign rs1_addr  = if_id_ir[19:15];
    assign rs2_addr  = if_id_ir[24:20];
    assign wb_opcode = mem_wb_ir[6:0];
    assign wb_rd     = mem_wb_ir[11:7];
    assign unused_wb_bits = ^mem_wb_ir[31:12];

    // Stores and branches carry no rd; everything else (even opcode 0) writes a nonzero rd.
    assign wb_en = (wb_rd != 5'd0) && (wb_opcode != OP_STORE) && (wb_opcode != OP_BRANCH);

    always_comb begin
        imm_d = 20'h0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE:
                imm_d = {8'b0, if_id_ir[31:20]};
            OP_STORE:
                imm_d = {8'b0, if_id_ir[31:25], if_id_ir[11:7]};
            OP_BRANCH:
                imm_d = {8'b0, if_id_ir[31], if_id_ir[7], if_id_ir[30:25], if_id_ir[11:8]};
            OP_LUI, OP_AUIPC:
                imm_d = if_id_ir[31:12];
            OP_JAL:
                imm_d = {if_id_ir[31], if_id_ir[19:12], if_id_ir[20], if_id_ir[30:21]};
            OP_REG:
                imm_d = 20'h0;
            default:
                imm_d = 20'h0;
        endcase
    end

    always_comb begin
        rs1_d = (rs1_addr == 5'd0) ? 32'h0 : regs_q[rs1_addr];
        rs2_d = (rs2_addr == 5'd0) ? 32'h0 : regs_q[rs2_addr];
`ifdef RV_DECODE_WB_BYPASS_EN
        // wb_en already excludes rd == 0, so x0 never forwards.
        if (wb_en && (wb_rd == rs1_addr)) rs1_d = mem_wb_out;
        if (wb_en && (wb_rd == rs2_addr)) rs2_d = mem_wb_out;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (wb_en) begin
            regs_q[wb_rd] <= mem_wb_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q  <= 32'h0;
            pc_q  <= 32'h0;
            rs1_q <= 32'h0;
            rs2_q <= 32'h0;
            imm_q <= 20'h0;
        end else begin
            ir_q  <= if_id_ir;
            pc_q  <= if_id_pc;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            imm_q <= imm_d;
        end
    end

    assign id_ex_ir  = ir_q;
    assign id_ex_pc  = pc_q;
    assign id_ex_rs1 = rs1_q;
    assign id_ex_rs2 = rs2_q;
    assign id_ex_imm = imm_q;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: a reference register-file model feeds an expected-result queue,
// popped one cycle after each drive; extra directed constant checks cover the immediate and regfile cases.
module tb_rv_decode_stage;
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [19:0] imm;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_pc;
    logic [31:0] mem_wb_ir;
    logic [31:0] mem_wb_out;
    logic [31:0] id_ex_ir;
    logic [31:0] id_ex_pc;
    logic [31:0] id_ex_rs1;
    logic [31:0] id_ex_rs2;
    logic [19:0] id_ex_imm;

    exp_t        exp_q[$];
    logic [31:0] model_regs [0:31];
    int          checks;
    int          failures;

    rv_decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .if_id_ir   (if_id_ir),
        .if_id_pc   (if_id_pc),
        .mem_wb_ir  (mem_wb_ir),
        .mem_wb_out (mem_wb_out),
        .id_ex_ir   (id_ex_ir),
        .id_ex_pc   (id_ex_pc),
        .id_ex_rs1  (id_ex_rs1),
        .id_ex_rs2  (id_ex_rs2),
        .id_ex_imm  (id_ex_imm)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] model_imm(input logic [31:0] ir);
        case (ir[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111:
                return {8'b0, ir[31:20]};
            7'b0100011: return {8'b0, ir[31:25], ir[11:7]};
            7'b1100011: return {8'b0, ir[31], ir[7], ir[30:25], ir[11:8]};
            7'b0110111, 7'b0010111: return ir[31:12];
            7'b1101111: return {ir[31], ir[19:12], ir[20], ir[30:21]};
            default: return 20'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: applies one cycle of stimulus and pushes the expected ID/EX contents.
    task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] wb_ir, input logic [31:0] wb_out);
        exp_t e;
        logic we;
        logic [4:0] a1;
        logic [4:0] a2;
        if_id_ir   = ir;
        if_id_pc   = pc;
        mem_wb_ir  = wb_ir;
        mem_wb_out = wb_out;
        a1 = ir[19:15];
        a2 = ir[24:20];
        we = (wb_ir[11:7] != 5'd0) && (wb_ir[6:0] != 7'b0100011) && (wb_ir[6:0] != 7'b1100011);
        e.ir  = ir;
        e.pc  = pc;
        e.imm = model_imm(ir);
        e.rs1 = model_regs[a1];
        e.rs2 = model_regs[a2];
`ifdef RV_DECODE_WB_BYPASS_EN
        if (we && wb_ir[11:7] == a1) e.rs1 = wb_out;
        if (we && wb_ir[11:7] == a2) e.rs2 = wb_out;
`endif
        if (we) model_regs[wb_ir[11:7]] = wb_out;
        exp_q.push_back(e);
    endtask

    // Scoreboard: one edge later, pop and compare all five outputs.
    task automatic step(input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] wb_ir, input logic [31:0] wb_out);
        exp_t e;
        drive(ir, pc, wb_ir, wb_out);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            check("ir",  id_ex_ir,  e.ir);
            check("pc",  id_ex_pc,  e.pc);
            check("rs1", id_ex_rs1, e.rs1);
            check("rs2", id_ex_rs2, e.rs2);
            check("imm", {12'h0, id_ex_imm}, {12'h0, e.imm});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ir"},  id_ex_ir,  32'h0);
        check({tag, "_pc"},  id_ex_pc,  32'h0);
        check({tag, "_rs1"}, id_ex_rs1, 32'h0);
        check({tag, "_rs2"}, id_ex_rs2, 32'h0);
        check({tag, "_imm"}, {12'h0, id_ex_imm}, 32'h0);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        logic [31:0] old_x7;
        checks = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        rst = 1'b1;
        if_id_ir = 32'h0;
        if_id_pc = 32'h0;
        mem_wb_ir = 32'h0;
        mem_wb_out = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Immediates with all field bits set
        step({25'h1ffffff, 7'b0000011}, 32'h100, 32'h0, 32'h0);
        check("imm_i", {12'h0, id_ex_imm}, 32'h0000_0fff);
        step({25'h1ffffff, 7'b0100011}, 32'h104, 32'h0, 32'h0);
        check("imm_s", {12'h0, id_ex_imm}, 32'h0000_0fff);
        step({25'h1ffffff, 7'b1100011}, 32'h108, 32'h0, 32'h0);
        check("imm_b", {12'h0, id_ex_imm}, 32'h0000_0fff);
        step({25'h1ffffff, 7'b0110111}, 32'h10c, 32'h0, 32'h0);
        check("imm_u", {12'h0, id_ex_imm}, 32'h000f_ffff);
        step({25'h1ffffff, 7'b1101111}, 32'h110, 32'h0, 32'h0);
        check("imm_j", {12'h0, id_ex_imm}, 32'h000f_ffff);
        step({25'h1ffffff, 7'b0110011}, 32'h114, 32'h0, 32'h0);
        check("imm_r", {12'h0, id_ex_imm}, 32'h0);
        step({20'hfffff, 5'h0, 7'b1001100}, 32'h118, 32'h0, 32'h0);
        check("imm_illegal", {12'h0, id_ex_imm}, 32'h0);
        check("illegal_ir", id_ex_ir, {20'hfffff, 5'h0, 7'b1001100});

        // Writeback to x4, then read it
        step(NOP, 32'h11c, {20'h0, 5'd4, 7'b0110011}, 32'hdeadbeef);
        step({12'h0, 5'd4, 3'b0, 5'd1, 7'b0010011}, 32'h120, 32'h0, 32'h0);
        check("x4_read", id_ex_rs1, 32'hdeadbeef);

        // Writeback to x0 is discarded
        step(NOP, 32'h124, {20'h0, 5'd0, 7'b0110011}, 32'hdeadbeef);
        step({12'h0, 5'd0, 3'b0, 5'd1, 7'b0010011}, 32'h128, 32'h0, 32'h0);
        check("x0_read", id_ex_rs1, 32'h0);

        // Store-opcode writeback must not write x5
        step(NOP, 32'h12c, {20'h0, 5'd5, 7'b0110111}, 32'h1111_1111);
        step(NOP, 32'h130, {20'h0, 5'd5, 7'b0100011}, 32'h1234_5678);
        step({12'h0, 5'd5, 3'b0, 5'd1, 7'b0010011}, 32'h134, 32'h0, 32'h0);
        check("x5_store_suppressed", id_ex_rs1, 32'h1111_1111);

        // Same-edge write of x7 while reading rs2=7
        old_x7 = 32'h0bad_f00d;
        step(NOP, 32'h138, {20'h0, 5'd7, 7'b0000011}, old_x7);
        step({7'h0, 5'd7, 5'd0, 3'b0, 5'd0, 7'b0110011}, 32'h13c, {20'h0, 5'd7, 7'b0110011}, 32'hcafe_f00d);
`ifdef RV_DECODE_WB_BYPASS_EN
        check("x7_same_edge", id_ex_rs2, 32'hcafe_f00d);
`else
        check("x7_same_edge", id_ex_rs2, old_x7);
`endif
        step({7'h0, 5'd7, 5'd0, 3'b0, 5'd0, 7'b0110011}, 32'h140, 32'h0, 32'h0);
        check("x7_after", id_ex_rs2, 32'hcafe_f00d);

        // Random traffic: pass-through and regfile model
        for (int i = 0; i < 24; i++) begin
            step($urandom(), $urandom(), $urandom(), $urandom());
        end
        step(32'h00f0_0013, 32'h0000_2000, 32'h0, 32'h0);

        // Asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rst = 1'b0;
        step({12'h0, 5'd4, 3'b0, 5'd1, 7'b0010011}, 32'h200, 32'h0, 32'h0);
        check("x4_after_rst", id_ex_rs1, 32'h0);
        step({12'h0, 5'd5, 3'b0, 5'd1, 7'b0010011}, 32'h204, 32'h0, 32'h0);
        check("x5_after_rst", id_ex_rs1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
